// File: rtl/lsu_requester.sv
// Load/store requester: turns one M-stage access into one or two word-aligned
// memory beats, then merges and extends load data into a single response.
module lsu_requester #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, err_q, err_d;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] b0_q, b0_d, b1_q, b1_d, rdata_q, rdata_d;

    function automatic logic [2:0] nbytes_f(input logic [2:0] sz);
        case (sz[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic cross_f(input logic [2:0] sz, input logic [1:0] off);
        return ({1'b0, off} + nbytes_f(sz)) > 3'd4;
    endfunction

    logic       acc_err, cross_q;
    logic [1:0] off_q;
    logic [3:0] mask4;
    logic [7:0] mask8;
    logic [63:0] data64, sh64;
    logic [31:0] ext;

    assign acc_err = (req_size == 3'b011) || (req_size == 3'b110) || (req_size == 3'b111)
                   || (req_we && req_size[2])
                   || (!SPLIT_EN && cross_f(req_size, req_addr[1:0]));

    assign off_q   = addr_q[1:0];
    assign cross_q = cross_f(size_q, off_q);
    assign mask4   = (size_q[1:0] == 2'b00) ? 4'b0001 :
                     (size_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign mask8   = {4'b0000, mask4} << off_q;
    assign data64  = {32'h0, wdata_q} << {off_q, 3'b000};

    // Beat words are concatenated so a crossing load shifts as one 64-bit value.
    assign sh64 = {b1_d, b0_d} >> {off_q, 3'b000};
    always_comb begin
        case (size_q)
            3'b000:  ext = {{24{sh64[7]}}, sh64[7:0]};
            3'b001:  ext = {{16{sh64[15]}}, sh64[15:0]};
            3'b100:  ext = {24'h0, sh64[7:0]};
            3'b101:  ext = {16'h0, sh64[15:0]};
            default: ext = sh64[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            b0_q    <= 32'h0;
            b1_q    <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = acc_err ? RESP : REQ0;
                err_d   = acc_err;
            end
            REQ0: if (mem_gnt)
                state_d = !we_q ? WAIT0 : (cross_q ? REQ1 : RESP);
            WAIT0: if (mem_rvalid) begin
                b0_d    = mem_rdata;
                state_d = cross_q ? REQ1 : RESP;
            end
            REQ1: if (mem_gnt)
                state_d = we_q ? RESP : WAIT1;
            WAIT1: if (mem_rvalid) begin
                b1_d    = mem_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = rdata_q;
        if (state_d == RESP && state_q != RESP)
            rdata_d = (we_q || err_d) ? 32'h0 : ext;
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        mem_req   = (state_q == REQ0) || (state_q == REQ1);
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0;
        mem_wdata = 32'h0;
        if (state_q == REQ0) begin
            mem_we    = we_q;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_be    = mask8[3:0];
            mem_wdata = data64[31:0];
        end else if (state_q == REQ1) begin
            mem_we    = we_q;
            mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_be    = mask8[7:4];
            mem_wdata = data64[63:32];
        end
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_lsu_requester.sv
// Bench for lsu_requester: vector table driven through a memory responder, with
// beat and response scoreboards plus reset / no-split corner sequences.
module tb_lsu_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_we, mem_req, mem_gnt, mem_we;
    logic        mem_rvalid, rsp_valid, rsp_err, busy;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, rsp_rdata;
    logic [3:0]  mem_be;

    logic        req_valid2, req_ready2, req_we2, mem_req2, mem_gnt2, mem_we2;
    logic        mem_rvalid2, rsp_valid2, rsp_err2, busy2;
    logic [2:0]  req_size2;
    logic [31:0] req_addr2, req_wdata2, mem_addr2, mem_wdata2, mem_rdata2, rsp_rdata2;
    logic [3:0]  mem_be2;

    lsu_requester #(.SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    lsu_requester #(.SPLIT_EN(1'b0)) u_nosplit (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_size(req_size2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .mem_req(mem_req2), .mem_gnt(mem_gnt2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2)
    );

    typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} beat_t;
    typedef struct {logic [31:0] rdata; logic err; int lat;} rsp_t;
    typedef struct {
        logic we; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata;
        int stall; int nb; beat_t b0; beat_t b1; logic [31:0] rdata; logic err; int lat;
    } vec_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    logic [31:0] mem [logic [31:0]];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int stall_left = 0;
    logic drop_rv = 1'b0, late_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic beat_t mkb(input logic [31:0] a, input logic [3:0] be,
                                  input logic [31:0] wd, input logic we);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = wd; b.we = we;
        return b;
    endfunction

    // Memory responder: grants after stall_left cycles, read data one cycle after grant.
    initial begin
        logic        rd_pend, have_snap;
        logic [31:0] rd_word;
        beat_t       snap, e;
        rd_pend = 1'b0; have_snap = 1'b0; rd_word = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid = (rd_pend && !drop_rv) || late_rv;
            mem_rdata  = rd_pend ? rd_word : 32'h0;
            late_rv    = 1'b0;
            rd_pend    = 1'b0;
            mem_gnt    = 1'b0;
            if (!mem_req) begin
                chk("idle be/we/wdata", {27'h0, mem_be, mem_we, mem_wdata}, 64'h0);
            end else if (stall_left > 0) begin
                stall_left--;
                if (!have_snap) begin
                    snap = mkb(mem_addr, mem_be, mem_wdata, mem_we);
                    have_snap = 1'b1;
                end else begin
                    chk("stall addr", {32'h0, mem_addr}, {32'h0, snap.addr});
                    chk("stall be/wdata", {28'h0, mem_be, mem_wdata}, {28'h0, snap.be, snap.wdata});
                end
            end else begin
                mem_gnt = 1'b1;
                have_snap = 1'b0;
                if (beat_q.size() == 0) begin
                    fail_evt($sformatf("unexpected beat addr %h", mem_addr));
                end else begin
                    e = beat_q.pop_front();
                    chk("beat addr", {32'h0, mem_addr}, {32'h0, e.addr});
                    chk("beat be", {60'h0, mem_be}, {60'h0, e.be});
                    chk("beat wdata", {32'h0, mem_wdata}, {32'h0, e.wdata});
                    chk("beat we", {63'h0, mem_we}, {63'h0, e.we});
                end
                if (!mem_we) begin
                    rd_pend = 1'b1;
                    rd_word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
            end
        end
    end

    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail_evt("unexpected rsp_valid");
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp rdata", {32'h0, rsp_rdata}, {32'h0, r.rdata});
                    chk("rsp err", {63'h0, rsp_err}, {63'h0, r.err});
                    chk("rsp latency", 64'(cyc - acc_cyc + 1), 64'(r.lat));
                end
            end
        end
    end

    task automatic wait_done(input int idx);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((rsp_q.size() != 0 || beat_q.size() != 0 || busy) && n < 60);
        if (rsp_q.size() != 0 || beat_q.size() != 0 || busy)
            fail_evt($sformatf("timeout vec %0d", idx));
        rsp_q.delete();
        beat_q.delete();
    endtask

    localparam int NV = 15;
    vec_t tv[NV];

    initial begin
        tv[0]  = '{1'b0, 3'b000, 32'h83, 32'h0, 0, 1, mkb(32'h80, 4'b1000, 0, 0), mkb(0, 0, 0, 0), 32'hFFFFFF88, 1'b0, 3};
        tv[1]  = '{1'b0, 3'b100, 32'h83, 32'h0, 0, 1, mkb(32'h80, 4'b1000, 0, 0), mkb(0, 0, 0, 0), 32'h00000088, 1'b0, 3};
        tv[2]  = '{1'b1, 3'b001, 32'h102, 32'h1234, 0, 1, mkb(32'h100, 4'b1100, 32'h12340000, 1), mkb(0, 0, 0, 0), 32'h0, 1'b0, 2};
        tv[3]  = '{1'b0, 3'b010, 32'h203, 32'h0, 0, 2, mkb(32'h200, 4'b1000, 0, 0), mkb(32'h204, 4'b0111, 0, 0), 32'h77665544, 1'b0, 5};
        tv[4]  = '{1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 0, 2, mkb(32'hFFFFFFFC, 4'b1100, 32'hCCDD0000, 1),
                   mkb(32'h0, 4'b0011, 32'h0000AABB, 1), 32'h0, 1'b0, 3};
        tv[5]  = '{1'b0, 3'b011, 32'h80, 32'h0, 0, 0, mkb(0, 0, 0, 0), mkb(0, 0, 0, 0), 32'h0, 1'b1, 1};
        tv[6]  = '{1'b1, 3'b100, 32'h80, 32'h55, 0, 0, mkb(0, 0, 0, 0), mkb(0, 0, 0, 0), 32'h0, 1'b1, 1};
        tv[7]  = '{1'b0, 3'b010, 32'h80, 32'h0, 5, 1, mkb(32'h80, 4'b1111, 0, 0), mkb(0, 0, 0, 0), 32'h8899AABB, 1'b0, 8};
        tv[8]  = '{1'b0, 3'b001, 32'h82, 32'h0, 0, 1, mkb(32'h80, 4'b1100, 0, 0), mkb(0, 0, 0, 0), 32'hFFFF8899, 1'b0, 3};
        tv[9]  = '{1'b0, 3'b101, 32'h80, 32'h0, 0, 1, mkb(32'h80, 4'b0011, 0, 0), mkb(0, 0, 0, 0), 32'h0000AABB, 1'b0, 3};
        tv[10] = '{1'b1, 3'b010, 32'h100, 32'h11223344, 5, 1, mkb(32'h100, 4'b1111, 32'h11223344, 1), mkb(0, 0, 0, 0), 32'h0, 1'b0, 7};
        tv[11] = '{1'b1, 3'b001, 32'h207, 32'h0000BEEF, 0, 2, mkb(32'h204, 4'b1000, 32'hEF000000, 1),
                   mkb(32'h208, 4'b0001, 32'h000000BE, 1), 32'h0, 1'b0, 3};
        tv[12] = '{1'b0, 3'b111, 32'h80, 32'h0, 0, 0, mkb(0, 0, 0, 0), mkb(0, 0, 0, 0), 32'h0, 1'b1, 1};
        tv[13] = '{1'b1, 3'b000, 32'h101, 32'h000000A5, 0, 1, mkb(32'h100, 4'b0010, 32'h0000A500, 1), mkb(0, 0, 0, 0), 32'h0, 1'b0, 2};
        tv[14] = '{1'b0, 3'b001, 32'h203, 32'h0, 0, 2, mkb(32'h200, 4'b1000, 0, 0), mkb(32'h204, 4'b0001, 0, 0), 32'h00005544, 1'b0, 5};

        mem[32'h80]  = 32'h8899AABB;
        mem[32'h200] = 32'h44332211;
        mem[32'h204] = 32'h88776655;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_size2 = 3'b0; req_addr2 = 32'h0; req_wdata2 = 32'h0;
        mem_gnt2 = 1'b1; mem_rvalid2 = 1'b0; mem_rdata2 = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset req_ready/busy", {62'h0, req_ready, busy}, 64'h2);
        chk("reset mem_req/rsp", {61'h0, mem_req, rsp_valid, rsp_err}, 64'h0);
        chk("reset mem_addr", {32'h0, mem_addr}, 64'h0);
        chk("reset rsp_rdata", {32'h0, rsp_rdata}, 64'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req_we = tv[i].we; req_size = tv[i].size; req_addr = tv[i].addr; req_wdata = tv[i].wdata;
            req_valid = 1'b1;
            stall_left = tv[i].stall;
            acc_cyc = cyc + 1;
            if (tv[i].nb > 0) beat_q.push_back(tv[i].b0);
            if (tv[i].nb > 1) beat_q.push_back(tv[i].b1);
            rsp_q.push_back('{tv[i].rdata, tv[i].err, tv[i].lat});
            @(negedge clk);
            req_valid = 1'b0;
            wait_done(i);
            if (!tv[i].err) chk($sformatf("rdata hold vec %0d", i), {32'h0, rsp_rdata}, {32'h0, tv[i].rdata});
        end

        // Reset while waiting for read data: transaction dropped, late rvalid ignored.
        @(negedge clk);
        drop_rv = 1'b1;
        req_we = 1'b0; req_size = 3'b010; req_addr = 32'h80; req_valid = 1'b1;
        beat_q.push_back(mkb(32'h80, 4'b1111, 0, 0));
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); #1;
        chk("busy in WAIT0", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        chk("mid-reset idle", {61'h0, busy, req_ready, mem_req}, 64'h2);
        chk("mid-reset rdata", {32'h0, rsp_rdata}, 64'h0);
        late_rv = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("after late rvalid busy", {63'h0, busy}, 64'h0);
        chk("beat queue drained", 64'(beat_q.size()), 64'h0);
        drop_rv = 1'b0;

        // No-split instance: a crossing halfword load errors without a memory beat.
        @(negedge clk);
        req_we2 = 1'b0; req_size2 = 3'b001; req_addr2 = 32'h3; req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        begin
            bit got = 1'b0;
            for (int k = 0; k < 6; k++) begin
                chk("nosplit mem_req", {63'h0, mem_req2}, 64'h0);
                chk("nosplit mem outs", {mem_addr2, 27'h0, mem_be2, mem_we2}, 64'h0);
                chk("nosplit wdata", {32'h0, mem_wdata2}, 64'h0);
                if (rsp_valid2) begin
                    got = 1'b1;
                    chk("nosplit rsp_err", {63'h0, rsp_err2}, 64'h1);
                    chk("nosplit rdata/busy", {31'h0, busy2, rsp_rdata2}, {31'h0, 1'b1, 32'h0});
                end
                @(negedge clk);
            end
            if (!got) fail_evt("nosplit no rsp_valid");
            chk("nosplit ready", {63'h0, req_ready2}, 64'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
